// File: rtl/layer_sequencer.sv
// layer_sequencer: evaluates one fully connected layer of SN neurons (SX
// inputs each) by time-multiplexing a single signed n x n multiplier.
// Each neuron takes INIT (bias load), SX MAC cycles and one ACT cycle; a
// one-cycle DONE closes the run, so start->done is SN*(SX+2)+1 cycles.

// Fixed-point format: Q8.24 (n = i + f = 8 + 24).

module layer_sequencer #(
    parameter int SX = 2,
    parameter int SN = 2,
    localparam int n = 32,
    localparam int f = 24
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [n*SX-1:0]     nx,
    input  logic [n*SX*SN-1:0]  nw,
    input  logic [n*SN-1:0]     nb,
    output logic                ready,
    output logic                busy,
    output logic                done,
    output logic [n*SN-1:0]     ny,
    output logic [n*SN-1:0]     nz
);

    // Counter widths: enough for the largest index, never below one bit.
    localparam int JW = (SX > 1) ? $clog2(SX) : 1;
    localparam int KW = (SN > 1) ? $clog2(SN) : 1;
    localparam logic [JW-1:0] J_LAST = JW'(SX - 1);
    localparam logic [KW-1:0] K_LAST = KW'(SN - 1);

    typedef enum logic [2:0] {IDLE, INIT, MAC, ACT, DONE} state_t;

    state_t                 state_q, state_d;
    logic [KW-1:0]          k_q, k_d;
    logic [JW-1:0]          j_q, j_d;
    logic signed [2*n-1:0]  acc_q, acc_d;

    // Operand snapshot taken at the accepting edge, so the sources may change
    // while the layer is being evaluated.
    logic [n-1:0]           x_q [SX];
    logic [n-1:0]           w_q [SN][SX];
    logic [n-1:0]           b_q [SN];
    logic [n-1:0]           nz_q [SN];
    logic [n-1:0]           ny_q [SN];

    logic                   accept;
    logic signed [2*n-1:0]  prod;
    logic signed [2*n-1:0]  bias_ext;
    logic [n-1:0]           z;
    logic                   acc_unused;

    assign accept   = (state_q == IDLE) && start;
    // The one and only multiplier: full-width signed product, no truncation.
    assign prod     = $signed(x_q[j_q]) * $signed(w_q[k_q][j_q]);
    assign bias_ext = $signed({{n{b_q[k_q][n-1]}}, b_q[k_q]});
    // Truncation drops f LSBs and keeps n bits; overflow simply wraps.
    assign z        = acc_q[f+n-1:f];
    assign acc_unused = ^{acc_q[2*n-1:f+n], acc_q[f-1:0]};

    assign ready = (state_q == IDLE);
    assign busy  = (state_q != IDLE);
    assign done  = (state_q == DONE);

    // State, neuron/input counters and accumulator registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            k_q     <= '0;
            j_q     <= '0;
            acc_q   <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            j_q     <= j_d;
            acc_q   <= acc_d;
        end
    end

    // Sequencing: next state, counter steps and accumulator update.
    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        j_d     = j_q;
        acc_d   = acc_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = INIT;
                    k_d     = '0;
                end
            end
            INIT: begin
                acc_d   = bias_ext <<< f;
                j_d     = '0;
                state_d = MAC;
            end
            MAC: begin
                acc_d = acc_q + prod;
                if (j_q == J_LAST) begin
                    state_d = ACT;
                end else begin
                    j_d = j_q + JW'(1);
                end
            end
            ACT: begin
                if (k_q == K_LAST) begin
                    state_d = DONE;
                end else begin
                    k_d     = k_q + KW'(1);
                    state_d = INIT;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    genvar gi, gj;

    // Per-input snapshot of x at the accepting edge.
    for (gi = 0; gi < SX; gi++) begin : g_x
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                x_q[gi] <= '0;
            end else if (accept) begin
                x_q[gi] <= nx[gi*n +: n];
            end
        end
    end

    for (gi = 0; gi < SN; gi++) begin : g_neuron
        // Per-neuron snapshot of bias and weights at the accepting edge.
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                b_q[gi] <= '0;
            end else if (accept) begin
                b_q[gi] <= nb[gi*n +: n];
            end
        end

        for (gj = 0; gj < SX; gj++) begin : g_w
            // Weight w[gi][gj] snapshot.
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    w_q[gi][gj] <= '0;
                end else if (accept) begin
                    w_q[gi][gj] <= nw[(gi*SX+gj)*n +: n];
                end
            end
        end

        // Result registers: written in this neuron's ACT cycle, held otherwise.
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                nz_q[gi] <= '0;
                ny_q[gi] <= '0;
            end else if ((state_q == ACT) && (k_q == KW'(gi))) begin
                nz_q[gi] <= z;
                ny_q[gi] <= z[n-1] ? '0 : z;
            end
        end

        assign nz[gi*n +: n] = nz_q[gi];
        assign ny[gi*n +: n] = ny_q[gi];
    end

endmodule

// File: tb/tb_layer_sequencer.sv
// Directed testbench for layer_sequencer: table of layer vectors on the
// default SX=2/SN=2 instance plus hand-written multi-cycle sequences and a
// SX=1/SN=1 instance for the minimum-size latency.
`timescale 1ns/1ps

module tb_layer_sequencer;

    localparam int N = 32;

    logic clk;
    logic rst_n;

    // Default-size instance.
    logic              start;
    logic [N*2-1:0]    nx;
    logic [N*4-1:0]    nw;
    logic [N*2-1:0]    nb;
    logic              ready, busy, done;
    logic [N*2-1:0]    ny, nz;

    // Minimum-size instance.
    logic              s_start;
    logic [N-1:0]      s_nx, s_nw, s_nb;
    logic              s_ready, s_busy, s_done;
    logic [N-1:0]      s_ny, s_nz;

    int tests_run = 0;
    int tests_failed = 0;

    layer_sequencer #(.SX(2), .SN(2)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .nx(nx), .nw(nw), .nb(nb),
        .ready(ready), .busy(busy), .done(done),
        .ny(ny), .nz(nz)
    );

    layer_sequencer #(.SX(1), .SN(1)) dut_small (
        .clk(clk), .rst_n(rst_n), .start(s_start),
        .nx(s_nx), .nw(s_nw), .nb(s_nb),
        .ready(s_ready), .busy(s_busy), .done(s_done),
        .ny(s_ny), .nz(s_nz)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [31:0] x0, x1;
        logic [31:0] w00, w01, w10, w11;
        logic [31:0] b0, b1;
        logic [31:0] z0, z1, y0, y1;
    } vec_t;

    vec_t vecs[4];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic load_vec(input vec_t v);
        nx = {v.x1, v.x0};
        nw = {v.w11, v.w10, v.w01, v.w00};
        nb = {v.b1, v.b0};
    endtask

    // Pulses start for one cycle and waits (bounded) for done; lat is the
    // number of cycles after the accepting edge at which done was observed.
    task automatic run_main(input bit scramble, output int lat);
        start = 1'b1;
        tick();
        start = 1'b0;
        if (scramble) begin
            nx = {$urandom, $urandom};
            nw = {$urandom, $urandom, $urandom, $urandom};
            nb = {$urandom, $urandom};
        end
        lat = 1;
        while (!done && lat < 50) begin
            tick();
            lat++;
        end
    endtask

    task automatic check_results(input string tag, input vec_t v);
        chk({tag, " nz0"}, {32'h0, nz[31:0]},  {32'h0, v.z0});
        chk({tag, " nz1"}, {32'h0, nz[63:32]}, {32'h0, v.z1});
        chk({tag, " ny0"}, {32'h0, ny[31:0]},  {32'h0, v.y0});
        chk({tag, " ny1"}, {32'h0, ny[63:32]}, {32'h0, v.y1});
    endtask

    initial begin
        int lat;
        int done_cnt;
        bit ready_seen;

        // x, weights, bias, expected truncated z and ReLU y (Q8.24).
        vecs[0] = '{"basic", 32'h01000000, 32'h02000000,
                    32'h00800000, 32'h00400000, 32'hFF000000, 32'hFF000000,
                    32'h00400000, 32'h00000000,
                    32'h01400000, 32'hFD000000, 32'h01400000, 32'h00000000};
        vecs[1] = '{"mixed", 32'hFF000000, 32'h00800000,
                    32'h03000000, 32'hFE000000, 32'h00800000, 32'h04000000,
                    32'h01000000, 32'hFF800000,
                    32'hFD000000, 32'h01000000, 32'h00000000, 32'h01000000};
        vecs[2] = '{"trunc", 32'hFFFFFFFF, 32'h00000000,
                    32'h00800000, 32'h00000000, 32'h00000000, 32'h00000000,
                    32'h00000000, 32'h7FFFFFFF,
                    32'hFFFFFFFF, 32'h7FFFFFFF, 32'h00000000, 32'h7FFFFFFF};
        vecs[3] = '{"wrap", 32'h40000000, 32'h40000000,
                    32'h02000000, 32'h00000000, 32'h00000000, 32'h02000000,
                    32'h00000000, 32'h00000000,
                    32'h80000000, 32'h80000000, 32'h00000000, 32'h00000000};

        rst_n = 1'b0; start = 1'b0; nx = '0; nw = '0; nb = '0;
        s_start = 1'b0; s_nx = '0; s_nw = '0; s_nb = '0;
        tick();
        tick();
        rst_n = 1'b1;
        chk("reset ready", {63'h0, ready}, 64'h1);
        chk("reset busy",  {63'h0, busy},  64'h0);
        chk("reset done",  {63'h0, done},  64'h0);

        // Table-driven layer evaluations.
        for (int v = 0; v < 4; v++) begin
            load_vec(vecs[v]);
            run_main(1'b0, lat);
            $display("[TB] vec %s lat=%0d nz=%h ny=%h", vecs[v].name, lat, nz, ny);
            chk({vecs[v].name, " latency"}, 64'(lat), 64'd9);
            check_results(vecs[v].name, vecs[v]);
            tick();
            chk({vecs[v].name, " done pulse"}, {62'h0, done, ready}, 64'h1);
        end

        // Reset after a prior run clears everything.
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        $display("[TB] reset after run nz=%h ny=%h ready=%0b busy=%0b", nz, ny, ready, busy);
        chk("reset2 status", {61'h0, ready, busy, done}, 64'h4);
        chk("reset2 nz", nz, 64'h0);
        chk("reset2 ny", ny, 64'h0);

        // Inputs scrambled right after the accepting edge must not matter.
        load_vec(vecs[0]);
        run_main(1'b1, lat);
        $display("[TB] isolation lat=%0d nz=%h ny=%h", lat, nz, ny);
        chk("isolation latency", 64'(lat), 64'd9);
        check_results("isolation", vecs[1 - 1]);
        tick();

        // start held high for the whole run: one done, ready low throughout.
        load_vec(vecs[1]);
        start = 1'b1;
        tick();
        done_cnt = 0;
        ready_seen = 1'b0;
        lat = 1;
        while (lat < 9) begin
            if (ready) ready_seen = 1'b1;
            if (done) done_cnt++;
            tick();
            lat++;
        end
        chk("held start done at 9", {63'h0, done}, 64'h1);
        chk("held start ready low", {63'h0, ready_seen}, 64'h0);
        chk("held start early done", 64'(done_cnt), 64'd0);
        tick();
        // Back in IDLE despite start still high during DONE.
        chk("held start idle", {62'h0, ready, done}, 64'h2);
        start = 1'b0;
        tick();
        $display("[TB] held-start run nz=%h ny=%h", nz, ny);
        check_results("held start", vecs[1]);

        // Reset during neuron 1's MAC phase aborts the evaluation.
        load_vec(vecs[0]);
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c < 6; c++) tick();
        chk("pre-abort nz0 written", {32'h0, nz[31:0]}, {32'h0, vecs[0].z0});
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        $display("[TB] abort nz=%h ny=%h ready=%0b busy=%0b", nz, ny, ready, busy);
        chk("abort status", {61'h0, ready, busy, done}, 64'h4);
        chk("abort nz", nz, 64'h0);
        chk("abort ny", ny, 64'h0);
        done_cnt = 0;
        for (int c = 0; c < 15; c++) begin
            if (done || busy) done_cnt++;
            tick();
        end
        chk("abort no activity", 64'(done_cnt), 64'd0);
        run_main(1'b0, lat);
        $display("[TB] after abort lat=%0d nz=%h ny=%h", lat, nz, ny);
        chk("after abort latency", 64'(lat), 64'd9);
        check_results("after abort", vecs[0]);
        tick();

        // Minimum size: 1.5 * -2.0 + 0.5 = -2.5, then 0.75 * 2.0 = 1.5.
        for (int t = 0; t < 2; t++) begin
            s_nx = (t == 0) ? 32'h01800000 : 32'h00C00000;
            s_nw = (t == 0) ? 32'hFE000000 : 32'h02000000;
            s_nb = (t == 0) ? 32'h00800000 : 32'h00000000;
            s_start = 1'b1;
            tick();
            s_start = 1'b0;
            lat = 1;
            while (!s_done && lat < 50) begin
                tick();
                lat++;
            end
            $display("[TB] small run %0d lat=%0d nz=%h ny=%h", t, lat, s_nz, s_ny);
            chk("small latency", 64'(lat), 64'd4);
            chk("small nz", {32'h0, s_nz}, (t == 0) ? 64'hFD800000 : 64'h01800000);
            chk("small ny", {32'h0, s_ny}, (t == 0) ? 64'h0 : 64'h01800000);
            tick();
            chk("small idle", {63'h0, s_ready}, 64'h1);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/layer_sequencer.md
Name: layer_sequencer

Overview:
- Time-multiplexes one signed fixed-point multiply-accumulate unit across all SN neurons of a fully connected layer, each with SX inputs.
- Replaces SN parallel combinational nodes with one multiplier, sequenced by an FSM.
- Produces per-neuron ReLU outputs and raw truncated MAC results in the same fixed-point format as the rest of the network (`n`, `f`, `i` from fixed_point.vh).
- Sits between the input/weight buffers and the next layer, under a start/done handshake.

Parameters:
- SX, 2, number of inputs per neuron (≥1)
- SN, 2, number of neurons in the layer (≥1)
- n/f/i, localparams from fixed_point.vh macros `n`/`f`/`i`, word width/fraction/integer bits (n=i+f)

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset
- start  in  1  request a layer evaluation; accepted only when ready=1
- nx  in  n*SX  concatenated inputs; x[j]=nx[j*n +: n], signed
- nw  in  n*SX*SN  weights; w[k][j]=nw[(k*SX+j)*n +: n], signed
- nb  in  n*SN  biases; b[k]=nb[k*n +: n], signed
- ready  out  1  high in IDLE only
- busy  out  1  high while evaluating
- done  out  1  single-cycle pulse when all SN results are valid
- ny  out  n*SN  ReLU outputs; ny[k*n +: n]
- nz  out  n*SN  truncated MAC results; nz[k*n +: n]

Behaviour:
- Reset (rst_n=0 at clk edge): state=IDLE, ready=1, busy=0, done=0, ny=0, nz=0, accumulator/counters=0. Reset wins over any other event in the same cycle, including mid-evaluation (abort; partial results discarded, outputs cleared).
- States: IDLE, INIT, MAC, ACT, DONE.
- IDLE: ready=1. start=1 → latch nx, nw, nb into internal registers, neuron k=0, go INIT. Inputs may change freely after the accepting edge.
- INIT: acc = sign-extended b[k] placed at fraction offset f (acc = b[k] << f, 2n-bit signed); j=0; → MAC.
- MAC: one product per cycle: acc = acc + x[j]*w[k][j], full 2n-bit signed product, no intermediate truncation; j increments; after j=SX-1 → ACT.
- ACT: z = acc[f+n-1:f] (drop f LSBs, keep n bits; overflow wraps, no saturation). Write nz[k]=z, ny[k] = (z<0) ? 0 : z. If k=SN-1 → DONE, else k++ → INIT.
- DONE: done=1 for exactly this cycle; → IDLE.
- busy=1 in INIT/MAC/ACT/DONE; ready=0 in those states; start ignored (not queued) while busy.
- Latency: start accepted at edge T → done high in cycle T + SN*(SX+2) + 1 (9 cycles for defaults).
- ny/nz of neuron k update at its ACT edge, stable in DONE. All hold until the next evaluation overwrites them or reset. Entries not yet rewritten keep previous-run values.
- Exactly one multiplier instance (n×n signed) is permitted.
- Counters sized $clog2 of max+1, minimum 1 bit, so SX=1 and SN=1 work.

Test Plan (f=24: 1.0=0x01000000):
- Reset: hold rst_n=0 for 2 cycles after a prior run → ready=1, busy=0, done=0, ny=nz=0.
- Basic, SX=2 SN=2: x={1.0,2.0}; neuron0 w={0.5,0.25}, b=0.25; neuron1 w={-1.0,-1.0}, b=0. Pulse start → done exactly 9 cycles later; nz0=ny0=0x01400000; nz1=0xFD000000, ny1=0.
- Input isolation: change nx/nw/nb the cycle after start → results identical to the basic test.
- start while busy: assert start every cycle during evaluation → single done pulse; next evaluation begins only after return to IDLE; ready low throughout.
- Reset mid-MAC: rst_n=0 during neuron1 MAC → next cycle state IDLE, outputs 0, no done pulse. Fresh start → correct results.
- Wrap: x={64.0,64.0}, w={2.0,0}, b=0 (i=8) → z wraps to 0x80000000 (-128.0), ny=0. Edge case SX=1/SN=1 → latency 4 cycles.
